// File: rtl/set_fifo_stream.sv
`default_nettype none
// ============================================================================
// Module   : set_fifo_stream
// Brief    : Settable value buffer. Pushed values are held in a small FIFO
//            and presented in order on a valid/ready stream. Sticky mode
//            re-streams the last held value indefinitely. The block also
//            provides an occupancy count, a sticky overflow flag and a
//            synchronous flush.
// Revision : 1.0 - initial release
// ============================================================================
module set_fifo_stream #(
    parameter int              WIDTH       = 32,
    parameter int              DEPTH       = 4,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           new_en,
    input  logic [WIDTH-1:0]               new_value,
    input  logic                           sticky,
    input  logic                           clear,
    output logic                           output__valid,
    output logic [WIDTH-1:0]               output__payload,
    input  logic                           output__ready,
    output logic [$clog2(DEPTH+1)-1:0]     count,
    output logic                           overflow
);

    localparam int                  c_PTR_W  = $clog2(DEPTH);
    localparam int                  c_CNT_W  = $clog2(DEPTH + 1);
    localparam logic [c_CNT_W-1:0]  c_FULL   = c_CNT_W'(DEPTH);
    localparam logic [c_CNT_W-1:0]  c_CNT_1  = c_CNT_W'(1);
    localparam logic [c_PTR_W-1:0]  c_PTR_1  = c_PTR_W'(1);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_CNT_W-1:0] r_count;
    logic               r_overflow;

    logic               w_empty;
    logic               w_full;
    logic               w_pop;
    logic               w_consume;
    logic               w_push;
    logic               w_drop;
    logic [c_CNT_W-1:0] w_count_nxt;
    logic [c_PTR_W-1:0] w_prev_ptr;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == c_FULL);

    // A handshake on the last entry in sticky mode leaves the entry in place.
    assign w_pop     = !w_empty && output__ready;
    assign w_consume = w_pop && !(sticky && (r_count == c_CNT_1));

    // A consuming pop frees a slot in the same cycle, so a full buffer can
    // still accept a push while it is draining.
    assign w_push = new_en && (!w_full || w_consume);
    assign w_drop = new_en && w_full && !w_consume;

    // When empty, rd_ptr == wr_ptr points at a stale slot. The slot just
    // behind rd_ptr holds the value most recently consumed (RESET_VALUE
    // after reset/clear), and that is what an idle output shows.
    assign w_prev_ptr = r_rd_ptr - c_PTR_1;

    assign output__valid   = !w_empty;
    assign output__payload = w_empty ? r_mem[w_prev_ptr] : r_mem[r_rd_ptr];
    assign count           = r_count;
    assign overflow        = r_overflow;

    // Occupancy next-state: push and consuming pop cancel each other.
    always_comb begin
        w_count_nxt = r_count;
        if (w_push && !w_consume) begin
            w_count_nxt = r_count + c_CNT_1;
        end else if (!w_push && w_consume) begin
            w_count_nxt = r_count - c_CNT_1;
        end
    end

    // Pointers, occupancy and overflow flag; reset and clear share one end state.
    always_ff @(posedge clk) begin
        if (!rst || clear) begin
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_consume) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_1;
            end
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_1;
            end
            r_count <= w_count_nxt;
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // Entry storage: flushed to RESET_VALUE, otherwise written at wr_ptr.
    always_ff @(posedge clk) begin
        if (!rst || clear) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= RESET_VALUE;
            end
        end else if (w_push) begin
            r_mem[r_wr_ptr] <= new_value;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_set_fifo_stream.sv
`default_nettype none
// ============================================================================
// Module   : tb_set_fifo_stream
// Brief    : Self-checking bench for set_fifo_stream. A queue-based model
//            predicts valid/payload/count/overflow after every clock.
// Revision : 1.0 - initial release
// ============================================================================
module tb_set_fifo_stream;

    localparam int               WIDTH = 32;
    localparam int               DEPTH = 4;
    localparam int               CNT_W = $clog2(DEPTH + 1);
    localparam logic [WIDTH-1:0] RV    = 32'hDEAD_BEEF;

    logic              clk = 1'b0;
    logic              rst;
    logic              new_en;
    logic [WIDTH-1:0]  new_value;
    logic              sticky;
    logic              clear;
    logic              output__valid;
    logic [WIDTH-1:0]  output__payload;
    logic              output__ready;
    logic [CNT_W-1:0]  count;
    logic              overflow;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    logic [WIDTH-1:0] q[$];
    logic [WIDTH-1:0] m_last;
    bit               m_ovf;

    set_fifo_stream #(
        .WIDTH       (WIDTH),
        .DEPTH       (DEPTH),
        .RESET_VALUE (RV)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .new_en          (new_en),
        .new_value       (new_value),
        .sticky          (sticky),
        .clear           (clear),
        .output__valid   (output__valid),
        .output__payload (output__payload),
        .output__ready   (output__ready),
        .count           (count),
        .overflow        (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Apply the rules for one rising edge to the model, using the inputs
    // being driven in that cycle.
    task automatic model_edge();
        bit pop;
        bit consume;
        int sz;
        if (!rst || clear) begin
            q.delete();
            m_ovf  = 1'b0;
            m_last = RV;
        end else begin
            sz      = q.size();
            pop     = (sz != 0) && output__ready;
            consume = pop && !(sticky && sz == 1);
            if (consume) m_last = q.pop_front();
            if (new_en) begin
                if (sz < DEPTH || consume) q.push_back(new_value);
                else m_ovf = 1'b1;
            end
        end
    endtask

    task automatic check_all(input string tag);
        logic [WIDTH-1:0] exp_pay;
        exp_pay = (q.size() != 0) ? q[0] : m_last;
        check({tag, ".valid"},   64'(output__valid), 64'(q.size() != 0));
        check({tag, ".payload"}, 64'(output__payload), 64'(exp_pay));
        check({tag, ".count"},   64'(count), 64'(q.size()));
        check({tag, ".overflow"},64'(overflow), 64'(m_ovf));
    endtask

    task automatic step(input string tag, input bit r, input bit c, input bit ne,
                        input logic [WIDTH-1:0] v, input bit st, input bit rd);
        @(negedge clk);
        rst = r; clear = c; new_en = ne; new_value = v; sticky = st; output__ready = rd;
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    initial begin
        rst = 1'b0; clear = 1'b0; new_en = 1'b0; new_value = '0;
        sticky = 1'b0; output__ready = 1'b0;
        q.delete(); m_last = RV; m_ovf = 1'b0;

        // Reset state
        step("rst0", 0, 0, 0, '0, 0, 0);
        step("rst1", 0, 0, 0, '0, 0, 0);
        check("rst.payload_const", 64'(output__payload), 64'(RV));

        // Single push, hold, then one handshake
        step("push11", 1, 0, 1, 32'h11, 0, 0);
        step("hold11", 1, 0, 0, '0, 0, 0);
        step("pop11",  1, 0, 0, '0, 0, 1);
        check("pop11.idle_payload", 64'(output__payload), 64'h11);

        // Fill and overflow, then drain; overflow persists until clear
        for (int i = 1; i <= 5; i++) step("fill", 1, 0, 1, 32'(i), 0, 0);
        for (int i = 0; i < 4; i++)  step("drain", 1, 0, 0, '0, 0, 1);
        check("drain.ovf_const", 64'(overflow), 64'h1);
        step("clr_ovf", 1, 1, 0, '0, 0, 0);

        // Full buffer with simultaneous push and pop
        for (int i = 1; i <= 4; i++) step("fill2", 1, 0, 1, 32'(i), 0, 0);
        step("full_pp", 1, 0, 1, 32'h9, 0, 1);
        for (int i = 0; i < 4; i++)  step("drain2", 1, 0, 0, '0, 0, 1);

        // Sticky re-streaming
        step("st_a", 1, 0, 1, 32'hA, 1, 1);
        step("st_b", 1, 0, 1, 32'hB, 1, 1);
        for (int i = 0; i < 4; i++) step("st_run", 1, 0, 0, '0, 1, 1);
        step("st_c", 1, 0, 1, 32'hC, 1, 1);
        for (int i = 0; i < 4; i++) step("st_runc", 1, 0, 0, '0, 1, 1);
        check("sticky.head_const", 64'(output__payload), 64'hC);

        // Wrap-around with push/pop pairs
        step("wr_clr", 1, 1, 0, '0, 0, 0);
        for (int i = 0; i < 10; i++) step("wrap", 1, 0, 1, 32'(i), 0, 1);
        step("wrap_end", 1, 0, 0, '0, 0, 1);

        // Clear mid-operation with a concurrent push
        for (int i = 0; i < 3; i++) step("pre_clr", 1, 0, 1, 32'(20 + i), 0, 0);
        step("clr_mid", 1, 1, 1, 32'h77, 0, 1);
        // Reset mid-operation overrides clear and push
        for (int i = 0; i < 3; i++) step("pre_rst", 1, 0, 1, 32'(30 + i), 0, 0);
        step("rst_mid", 0, 1, 1, 32'h88, 0, 1);
        check("rst_mid.payload_const", 64'(output__payload), 64'(RV));

        // Randomised traffic
        for (int i = 0; i < 600; i++) begin
            step("rand",
                 ($urandom_range(0, 99) >= 2),
                 ($urandom_range(0, 99) < 3),
                 ($urandom_range(0, 99) < 55),
                 $urandom,
                 ($urandom_range(0, 99) < 25),
                 ($urandom_range(0, 99) < 50));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
